// File: rtl/uart_rx_frame_shifter.sv
// Oversampling UART receiver: start-bit validation, LSB-first data shift, optional
// parity, one or two stop bits, and a valid/ready frame output with overrun status.
module uart_rx_frame_shifter #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               r_state, w_stateNext;
  logic                 r_rxMeta, r_rxSync;
  logic [TW-1:0]        r_tickCnt, w_tickCntNext;
  logic [BW-1:0]        r_bitCnt, w_bitCntNext;
  logic [DATA_BITS-1:0] r_shift, w_shiftNext;
  logic                 r_frmErr, w_frmErrNext;
  logic                 r_parErr, w_parErrNext;
  logic                 w_frameDone;
  logic                 w_bitEnd;
  logic [DATA_BITS-1:0] r_dataOut;
  logic                 r_valid, r_frameErrOut, r_parityErrOut, r_overrun;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= i_rx;
      r_rxSync <= r_rxMeta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_tickCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_frmErr  <= 1'b0;
      r_parErr  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_tickCnt <= w_tickCntNext;
      r_bitCnt  <= w_bitCntNext;
      r_shift   <= w_shiftNext;
      r_frmErr  <= w_frmErrNext;
      r_parErr  <= w_parErrNext;
    end
  end

  assign w_bitEnd = (r_tickCnt == FULL_LAST);

  always_comb begin
    w_stateNext   = r_state;
    w_tickCntNext = r_tickCnt;
    w_bitCntNext  = r_bitCnt;
    w_shiftNext   = r_shift;
    w_frmErrNext  = r_frmErr;
    w_parErrNext  = r_parErr;
    w_frameDone   = 1'b0;
    if (i_tick) begin
      case (r_state)
        IDLE: begin
          if (!r_rxSync) begin
            w_stateNext   = START;
            w_tickCntNext = '0;
          end
        end
        START: begin
          if (r_tickCnt == HALF_LAST) begin
            w_tickCntNext = '0;
            if (!r_rxSync) begin
              w_stateNext  = DATA;
              w_bitCntNext = '0;
              w_frmErrNext = 1'b0;
              w_parErrNext = 1'b0;
            end else begin
              w_stateNext = IDLE;
            end
          end else begin
            w_tickCntNext = r_tickCnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            w_tickCntNext = '0;
            w_shiftNext   = {r_rxSync, r_shift[DATA_BITS-1:1]};
            if (r_bitCnt == DATA_LAST) begin
              w_bitCntNext = '0;
              w_stateNext  = (PARITY != 0) ? PAR : STOP;
            end else begin
              w_bitCntNext = r_bitCnt + 1'b1;
            end
          end else begin
            w_tickCntNext = r_tickCnt + 1'b1;
          end
        end
        PAR: begin
          if (w_bitEnd) begin
            w_tickCntNext = '0;
            w_bitCntNext  = '0;
            w_stateNext   = STOP;
            w_parErrNext  = (PARITY == 1) ? (^{r_shift, r_rxSync}) : ~(^{r_shift, r_rxSync});
          end else begin
            w_tickCntNext = r_tickCnt + 1'b1;
          end
        end
        STOP: begin
          // The last stop sample ends the frame immediately so back-to-back frames are caught.
          if (w_bitEnd) begin
            w_tickCntNext = '0;
            w_frmErrNext  = r_frmErr | ~r_rxSync;
            if (r_bitCnt == STOP_LAST) begin
              w_bitCntNext = '0;
              w_stateNext  = IDLE;
              w_frameDone  = 1'b1;
            end else begin
              w_bitCntNext = r_bitCnt + 1'b1;
            end
          end else begin
            w_tickCntNext = r_tickCnt + 1'b1;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // A new frame replaces the held one only if the held one is gone or leaving this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dataOut      <= '0;
      r_valid        <= 1'b0;
      r_frameErrOut  <= 1'b0;
      r_parityErrOut <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (r_valid && i_ready) begin
        r_overrun <= 1'b0;
      end
      if (w_frameDone) begin
        if (!r_valid || i_ready) begin
          r_dataOut      <= w_shiftNext;
          r_frameErrOut  <= w_frmErrNext;
          r_parityErrOut <= w_parErrNext;
          r_valid        <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data_out   = r_dataOut;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_frameErrOut;
  assign o_parity_err = r_parityErrOut;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_shifter.sv
// Bench for uart_rx_frame_shifter: two receivers (no parity/1 stop, even parity/2 stops)
// driven with directed and random frames, checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_frame_shifter;

  localparam int DW       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;

  typedef struct {
    int            det;
    int            fin;
    bit            deliver;
    logic [DW-1:0] data;
    bit            fe;
    bit            pe;
  } activity_t;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic                tick = 1'b0;
  logic [1:0]          rxLine = 2'b11;
  logic [1:0]          readyIn = 2'b00;
  logic [1:0][DW-1:0]  dataOut;
  logic [1:0]          validOut, frameErr, parityErr, overrunOut, busyOut;

  int        testsRun = 0;
  int        testsFailed = 0;
  int        tickIdx = 0;
  bit        randReady = 1'b0;
  bit        lastTick = 1'b0;
  activity_t q0[$];
  activity_t q1[$];
  bit            mValid[2];
  bit            mOver[2];
  bit            mFe[2];
  bit            mPe[2];
  logic [DW-1:0] mData[2];

  uart_rx_frame_shifter #(.DATA_BITS(DW), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_tick(tick), .i_rx(rxLine[0]),
    .o_data_out(dataOut[0]), .o_valid(validOut[0]), .i_ready(readyIn[0]),
    .o_frame_err(frameErr[0]), .o_parity_err(parityErr[0]),
    .o_overrun(overrunOut[0]), .o_busy(busyOut[0])
  );

  uart_rx_frame_shifter #(.DATA_BITS(DW), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(OS)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_tick(tick), .i_rx(rxLine[1]),
    .o_data_out(dataOut[1]), .o_valid(validOut[1]), .i_ready(readyIn[1]),
    .o_frame_err(frameErr[1]), .o_parity_err(parityErr[1]),
    .o_overrun(overrunOut[1]), .o_busy(busyOut[1])
  );

  always #5 clk = ~clk;

  initial begin
    int divCnt;
    divCnt = 0;
    forever begin
      @(negedge clk);
      divCnt = (divCnt + 1) % TICK_DIV;
      tick = (divCnt == 0);
    end
  end

  function automatic int parOf(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int stopsOf(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit peekAct(input int d, output activity_t a);
    if (d == 0 && q0.size() > 0) begin a = q0[0]; return 1'b1; end
    if (d == 1 && q1.size() > 0) begin a = q1[0]; return 1'b1; end
    a = '{default: 0};
    return 1'b0;
  endfunction

  task automatic pushAct(input int d, input activity_t a);
    if (d == 0) q0.push_back(a);
    else q1.push_back(a);
  endtask

  task automatic popAct(input int d);
    if (d == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: each activity completes on a known tick, then the handshake rules apply.
  task automatic modelStep(input int d);
    activity_t a;
    bit accept;
    bit done;
    if (!rstN) begin
      mValid[d] = 1'b0; mOver[d] = 1'b0; mFe[d] = 1'b0; mPe[d] = 1'b0; mData[d] = '0;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    accept = mValid[d] && readyIn[d];
    done = 1'b0;
    if (tick && peekAct(d, a) && a.fin == tickIdx) begin
      popAct(d);
      done = a.deliver;
    end
    if (accept) mOver[d] = 1'b0;
    if (done) begin
      if (!mValid[d] || readyIn[d]) begin
        mValid[d] = 1'b1; mData[d] = a.data; mFe[d] = a.fe; mPe[d] = a.pe;
      end else begin
        mOver[d] = 1'b1;
      end
    end else if (accept) begin
      mValid[d] = 1'b0;
    end
  endtask

  task automatic compareCycle(input int d);
    activity_t a;
    bit busyExp;
    logic [31:0] act;
    logic [31:0] exp;
    busyExp = peekAct(d, a) && tickIdx >= a.det && tickIdx < a.fin;
    exp = {19'd0, mValid[d], mOver[d], busyExp,
           mValid[d] ? {mData[d], mFe[d], mPe[d]} : {DW + 2{1'b0}}};
    act = {19'd0, validOut[d], overrunOut[d], busyOut[d],
           mValid[d] ? {dataOut[d], frameErr[d], parityErr[d]} : {DW + 2{1'b0}}};
    checkOutput($sformatf("cycle dut%0d t=%0t {valid,ovr,busy,data,fe,pe}", d, $time), act, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (tick) tickIdx++;
      for (int d = 0; d < 2; d++) modelStep(d);
      #1;
      for (int d = 0; d < 2; d++) compareCycle(d);
    end
  end

  task automatic stepClk();
    @(posedge clk);
    lastTick = tick;
    @(negedge clk);
    if (randReady) begin
      readyIn[0] = ($urandom_range(0, 499) == 0);
      readyIn[1] = ($urandom_range(0, 499) == 0);
    end
  endtask

  task automatic waitTick();
    do stepClk(); while (!lastTick);
  endtask

  task automatic accept(input int d);
    readyIn[d] = 1'b1;
    stepClk();
    readyIn[d] = 1'b0;
  endtask

  // Drives one frame; a positive abortBits stops after that many line bits.
  task automatic applyStimulus(input int d, input logic [DW-1:0] data, input bit pbit,
                               input bit stop0, input bit stop1, input int abortBits);
    bit        line[$];
    activity_t a;
    int        nb;
    bit        lastStop;
    waitTick();
    line.push_back(1'b0);
    for (int i = 0; i < DW; i++) line.push_back(data[i]);
    if (parOf(d) != 0) line.push_back(pbit);
    line.push_back(stop0);
    if (stopsOf(d) == 2) line.push_back(stop1);
    lastStop = line[line.size() - 1];
    a.det = tickIdx + 1;
    a.fin = a.det + OS / 2 + OS * (line.size() - 1);
    a.deliver = 1'b1;
    a.data = data;
    a.fe = !stop0 || (stopsOf(d) == 2 && !stop1);
    a.pe = (parOf(d) != 0) && ((^data) ^ pbit);
    pushAct(d, a);
    if (!lastStop && abortBits <= 0) begin
      // A low final stop bit looks like a new start edge that fails its mid-bit check.
      a.det = a.fin + 1;
      a.fin = a.det + OS / 2;
      a.deliver = 1'b0;
      pushAct(d, a);
    end
    nb = (abortBits > 0) ? abortBits : line.size();
    for (int b = 0; b < nb; b++) begin
      rxLine[d] = line[b];
      repeat (OS) waitTick();
    end
    if (abortBits <= 0) begin
      rxLine[d] = 1'b1;
      if (!lastStop) repeat (4) waitTick();
    end
  endtask

  task automatic falseStart(input int d);
    activity_t a;
    waitTick();
    a = '{default: 0};
    a.det = tickIdx + 1;
    a.fin = a.det + OS / 2;
    pushAct(d, a);
    rxLine[d] = 1'b0;
    repeat (4) waitTick();
    rxLine[d] = 1'b1;
  endtask

  task automatic checkAllReset(input string name);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("%s dut%0d outputs", name, d),
                  {19'd0, dataOut[d], validOut[d], frameErr[d], parityErr[d], overrunOut[d], busyOut[d]},
                  32'd0);
  endtask

  initial begin
    #2_000_000;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] rData;
    int            d;
    repeat (3) @(negedge clk);
    checkAllReset("reset");
    rstN = 1'b1;

    $display("[TB] basic frame 0xA5");
    applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("A5 valid", validOut[0], 1);
    checkOutput("A5 data", dataOut[0], 8'hA5);
    checkOutput("A5 flags", {frameErr[0], parityErr[0], overrunOut[0]}, 0);
    accept(0);
    checkOutput("A5 valid after handshake", validOut[0], 0);

    $display("[TB] even parity");
    applyStimulus(1, 8'h3C, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("3C good parity_err", parityErr[1], 0);
    checkOutput("3C good valid", validOut[1], 1);
    accept(1);
    applyStimulus(1, 8'h3C, 1'b1, 1'b1, 1'b1, 0);
    checkOutput("3C bad parity_err", parityErr[1], 1);
    checkOutput("3C bad data", dataOut[1], 8'h3C);
    accept(1);

    $display("[TB] stop bit errors");
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
    checkOutput("55 stop low frame_err", frameErr[0], 1);
    checkOutput("55 stop low data", dataOut[0], 8'h55);
    checkOutput("55 stop low valid", validOut[0], 1);
    accept(0);
    applyStimulus(1, 8'h55, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("55 second stop low frame_err", frameErr[1], 1);
    checkOutput("55 second stop low parity_err", parityErr[1], 0);
    accept(1);

    $display("[TB] false start");
    falseStart(0);
    checkOutput("false start busy high", busyOut[0], 1);
    repeat (8) waitTick();
    checkOutput("false start busy low", busyOut[0], 0);
    checkOutput("false start valid", validOut[0], 0);

    $display("[TB] overrun");
    applyStimulus(0, 8'h11, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(0, 8'h22, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("overrun data kept", dataOut[0], 8'h11);
    checkOutput("overrun flag", overrunOut[0], 1);
    accept(0);
    checkOutput("overrun valid cleared", validOut[0], 0);
    checkOutput("overrun cleared", overrunOut[0], 0);
    applyStimulus(0, 8'h33, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("33 data", dataOut[0], 8'h33);
    checkOutput("33 valid", validOut[0], 1);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'hF0, 1'b0, 1'b1, 1'b1, 5);
    #2;
    rstN = 1'b0;
    rxLine = 2'b11;
    #1;
    checkAllReset("mid-frame reset");
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    applyStimulus(0, 8'h0F, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("0F after reset data", dataOut[0], 8'h0F);
    checkOutput("0F after reset valid", validOut[0], 1);
    accept(0);

    $display("[TB] random frames");
    randReady = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d = $urandom_range(0, 1);
      rData = DW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        falseStart(d);
        repeat (8) waitTick();
      end else begin
        applyStimulus(d, rData, (^rData) ^ ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 0);
      end
    end
    randReady = 1'b0;
    readyIn = 2'b11;
    repeat (3) stepClk();
    readyIn = 2'b00;
    repeat (4) stepClk();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
